bus_xbar_node: RTL and testbench

Parametrised NB_MASTER x NB_SLAVE crossbar for the req/gnt/rvalid memory protocol used by the cores and peripherals. It generalises the fixed three-port interconnect in two ways: the address map is a parameter, and each slave has its own round-robin arbiter. It also adds decode-error responses, in-order response routing through per-slave ID FIFOs, and a bound on outstanding transactions per slave. It sits between the core-region masters (core data, debug, SPI slave) and the memory and peripheral slaves at SoC top level.

---
 rtl/bus_xbar_node.sv | 222 ++++++++++++++++++++++
 tb/tb_bus_xbar_node.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_xbar_node.sv
// NB_MASTER x NB_SLAVE req/gnt/rvalid crossbar: address decode, per-slave round-robin, in-order ID FIFOs.
// Latency: request and response paths are combinational; decode-error response 1 cycle after grant.
// Backpressure: one outstanding access per master; a slave is not requested while its ID FIFO is full.

// Small FIFO holding master indices; the head is taken straight from storage.
module bus_xbar_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dat_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign dat_o   = mem_q[rd_q];

  // Pointer wrap and occupancy; simultaneous push and pop leave the count unchanged.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
    if (do_pop)  rd_d = (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and count state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage needs no reset: only entries below the count are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= dat_i;
  end
endmodule

module bus_xbar_node #(
  parameter int NB_MASTER       = 3,
  parameter int NB_SLAVE        = 3,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter logic [NB_SLAVE-1:0][ADDR_WIDTH-1:0] START_ADDR =
    {32'h1A10_0000, 32'h0010_0000, 32'h0000_0000},
  parameter logic [NB_SLAVE-1:0][ADDR_WIDTH-1:0] END_ADDR =
    {32'h1A11_FFFF, 32'h001F_FFFF, 32'h000F_FFFF}
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NB_MASTER-1:0]                    m_req_i,
  input  logic [NB_MASTER-1:0]                    m_we_i,
  input  logic [NB_MASTER-1:0][ADDR_WIDTH-1:0]    m_addr_i,
  input  logic [NB_MASTER-1:0][DATA_WIDTH-1:0]    m_wdata_i,
  input  logic [NB_MASTER-1:0][DATA_WIDTH/8-1:0]  m_be_i,
  output logic [NB_MASTER-1:0]                    m_gnt_o,
  output logic [NB_MASTER-1:0]                    m_rvalid_o,
  output logic [NB_MASTER-1:0]                    m_err_o,
  output logic [NB_MASTER-1:0][DATA_WIDTH-1:0]    m_rdata_o,
  output logic [NB_SLAVE-1:0]                     s_req_o,
  output logic [NB_SLAVE-1:0]                     s_we_o,
  output logic [NB_SLAVE-1:0][ADDR_WIDTH-1:0]     s_addr_o,
  output logic [NB_SLAVE-1:0][DATA_WIDTH-1:0]     s_wdata_o,
  output logic [NB_SLAVE-1:0][DATA_WIDTH/8-1:0]   s_be_o,
  input  logic [NB_SLAVE-1:0]                     s_gnt_i,
  input  logic [NB_SLAVE-1:0]                     s_rvalid_i,
  input  logic [NB_SLAVE-1:0][DATA_WIDTH-1:0]     s_rdata_i,
  output logic                                    proto_err_o
);
  localparam int MW = (NB_MASTER > 1) ? $clog2(NB_MASTER) : 1;
  localparam int SW = (NB_SLAVE > 1) ? $clog2(NB_SLAVE) : 1;

  logic [NB_MASTER-1:0]         hit, elig, derr_gnt;
  logic [NB_MASTER-1:0][SW-1:0] sel;
  logic [NB_MASTER-1:0]         busy_q, busy_d, derr_q, derr_d;
  logic [NB_SLAVE-1:0][MW-1:0]  rr_q, rr_d, win;
  logic [NB_SLAVE-1:0]          any, hs, full, empty, pop;
  logic [MW-1:0]                head [NB_SLAVE];

  // Address decode; scanning downward lets the lowest matching index win.
  // The range test uses wrapped subtraction so a zero base needs no special case.
  always_comb begin
    hit = '0;
    sel = '0;
    for (int m = 0; m < NB_MASTER; m++) begin
      for (int k = NB_SLAVE - 1; k >= 0; k--) begin
        if ((m_addr_i[m] - START_ADDR[k]) <= (END_ADDR[k] - START_ADDR[k])) begin
          hit[m] = 1'b1;
          sel[m] = SW'(k);
        end
      end
    end
  end

  assign elig     = m_req_i & ~busy_q;
  assign derr_gnt = elig & ~hit;

  // Per-slave round-robin: scan offsets downward so the one nearest rr_q wins.
  always_comb begin
    logic [MW-1:0] cand;
    int            idx;
    win  = '0;
    any  = '0;
    cand = '0;
    idx  = 0;
    for (int k = 0; k < NB_SLAVE; k++) begin
      for (int i = NB_MASTER - 1; i >= 0; i--) begin
        idx = int'(rr_q[k]) + i;
        if (idx >= NB_MASTER) idx = idx - NB_MASTER;
        cand = MW'(idx);
        if (elig[cand] && hit[cand] && (sel[cand] == SW'(k))) begin
          any[k] = 1'b1;
          win[k] = cand;
        end
      end
    end
  end

  assign s_req_o = any & ~full;
  assign hs      = s_req_o & s_gnt_i;

  // Winner's request fields drive the slave; idle slaves see zeros.
  always_comb begin
    s_we_o    = '0;
    s_addr_o  = '0;
    s_wdata_o = '0;
    s_be_o    = '0;
    rr_d      = rr_q;
    for (int k = 0; k < NB_SLAVE; k++) begin
      if (s_req_o[k]) begin
        s_we_o[k]    = m_we_i[win[k]];
        s_addr_o[k]  = m_addr_i[win[k]];
        s_wdata_o[k] = m_wdata_i[win[k]];
        s_be_o[k]    = m_be_i[win[k]];
      end
      if (hs[k]) rr_d[k] = (win[k] == MW'(NB_MASTER - 1)) ? '0 : win[k] + 1'b1;
    end
  end

  // Grant fan-back and response routing to the head of each slave's ID FIFO.
  always_comb begin
    m_gnt_o     = derr_gnt;
    m_rvalid_o  = derr_q;
    m_err_o     = derr_q;
    m_rdata_o   = '0;
    proto_err_o = 1'b0;
    pop         = '0;
    for (int k = 0; k < NB_SLAVE; k++) begin
      if (hs[k]) m_gnt_o[win[k]] = 1'b1;
      if (s_rvalid_i[k]) begin
        if (empty[k]) begin
          proto_err_o = 1'b1;
        end else begin
          pop[k]                = 1'b1;
          m_rvalid_o[head[k]]   = 1'b1;
          m_rdata_o[head[k]]    = s_rdata_i[k];
        end
      end
    end
  end

  // A master cannot be granted and answered in the same cycle, so set/clear never collide.
  assign busy_d = (busy_q | m_gnt_o) & ~m_rvalid_o;
  assign derr_d = derr_gnt;

  // Outstanding flags, pending decode errors and arbiter pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      derr_q <= '0;
      rr_q   <= '0;
    end else begin
      busy_q <= busy_d;
      derr_q <= derr_d;
      rr_q   <= rr_d;
    end
  end

  for (genvar k = 0; k < NB_SLAVE; k++) begin : g_id_fifo
    bus_xbar_fifo #(
      .WIDTH(MW),
      .DEPTH(MAX_OUTSTANDING)
    ) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .push_i (hs[k]),
      .dat_i  (win[k]),
      .pop_i  (pop[k]),
      .dat_o  (head[k]),
      .full_o (full[k]),
      .empty_o(empty[k])
    );
  end
endmodule

// File: tb/tb_bus_xbar_node.sv
module tb_bus_xbar_node;
  localparam int NM = 3;
  localparam int NS = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NM-1:0]          m_req_i, m_we_i;
  logic [NM-1:0][AW-1:0]  m_addr_i;
  logic [NM-1:0][DW-1:0]  m_wdata_i;
  logic [NM-1:0][3:0]     m_be_i;
  logic [NM-1:0]          m_gnt_o, m_rvalid_o, m_err_o;
  logic [NM-1:0][DW-1:0]  m_rdata_o;
  logic [NS-1:0]          s_req_o, s_we_o;
  logic [NS-1:0][AW-1:0]  s_addr_o;
  logic [NS-1:0][DW-1:0]  s_wdata_o;
  logic [NS-1:0][3:0]     s_be_o;
  logic [NS-1:0]          s_gnt_i, s_rvalid_i;
  logic [NS-1:0][DW-1:0]  s_rdata_i;
  logic                   proto_err_o;

  bus_xbar_node dut (
    .clk(clk), .rst_n(rst_n),
    .m_req_i(m_req_i), .m_we_i(m_we_i), .m_addr_i(m_addr_i),
    .m_wdata_i(m_wdata_i), .m_be_i(m_be_i),
    .m_gnt_o(m_gnt_o), .m_rvalid_o(m_rvalid_o), .m_err_o(m_err_o), .m_rdata_o(m_rdata_o),
    .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o),
    .s_wdata_o(s_wdata_o), .s_be_o(s_be_o),
    .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i),
    .proto_err_o(proto_err_o)
  );

  typedef struct packed {
    logic [1:0]  m;
    logic        err;
    logic [31:0] d;
  } rsp_t;

  int      checks = 0;
  int      errors = 0;
  int      exp_gnt[$];
  rsp_t    exp_rsp[$];
  logic [NM-1:0] tb_busy;
  int      mon_e;
  rsp_t    mon_r;

  function automatic rsp_t mk(input int m, input logic err, input logic [31:0] d);
    rsp_t r;
    r.m   = 2'(m);
    r.err = err;
    r.d   = d;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: grants and responses are popped from the expected queues as they appear.
  always @(negedge clk) begin
    if (!rst_n) begin
      tb_busy = '0;
    end else begin
      for (int m = 0; m < NM; m++) begin
        if (m_gnt_o[m]) begin
          chk("gnt_while_busy", 64'(tb_busy[m]), 64'd0);
          tb_busy[m] = 1'b1;
          if (exp_gnt.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_gnt: master %0d granted, none expected", m);
          end else begin
            mon_e = exp_gnt.pop_front();
            chk("gnt_order", 64'(m), 64'(mon_e));
          end
        end
      end
      for (int m = 0; m < NM; m++) begin
        if (m_rvalid_o[m]) begin
          tb_busy[m] = 1'b0;
          if (exp_rsp.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: master %0d rvalid, none expected", m);
          end else begin
            mon_r = exp_rsp.pop_front();
            chk("rsp_master", 64'(m), 64'(mon_r.m));
            chk("rsp_err", 64'(m_err_o[m]), 64'(mon_r.err));
            chk("rsp_data", 64'(m_rdata_o[m]), 64'(mon_r.d));
          end
        end
      end
    end
  end

  int ord [6] = '{0, 1, 2, 0, 1, 2};

  initial begin
    rst_n = 1'b0; tb_busy = '0;
    m_req_i = '0; m_we_i = '0; m_addr_i = '0; m_wdata_i = '0; m_be_i = '0;
    s_gnt_i = '0; s_rvalid_i = '0; s_rdata_i = '0;
    @(negedge clk);
    chk("rst_gnt", 64'(m_gnt_o), 64'd0);
    chk("rst_rvalid", 64'(m_rvalid_o), 64'd0);
    chk("rst_sreq", 64'(s_req_o), 64'd0);
    chk("rst_saddr", 64'(|s_addr_o), 64'd0);
    chk("rst_proto", 64'(proto_err_o), 64'd0);
    nxt(); rst_n = 1'b1;
    @(negedge clk);
    chk("idle_sreq", 64'(s_req_o), 64'd0);

    // Single read to slave 1, response 3 cycles later.
    nxt(); m_req_i = 3'b001; m_addr_i[0] = 32'h0010_0040; s_gnt_i = 3'b010; exp_gnt.push_back(0);
    @(negedge clk);
    chk("t1_sreq", 64'(s_req_o), 64'h2);
    chk("t1_saddr", 64'(s_addr_o[1]), 64'h0010_0040);
    chk("t1_swe", 64'(s_we_o), 64'd0);
    nxt(); m_req_i = '0; s_gnt_i = '0;
    @(negedge clk); chk("t1_wait1", 64'(m_rvalid_o), 64'd0);
    nxt();
    @(negedge clk); chk("t1_wait2", 64'(m_rvalid_o), 64'd0);
    nxt(); s_rvalid_i = 3'b010; s_rdata_i[1] = 32'hDEAD_BEEF; exp_rsp.push_back(mk(0, 1'b0, 32'hDEAD_BEEF));
    @(negedge clk);
    // Busy cleared: master 0 is granted again right away (a write this time).
    nxt(); s_rvalid_i = '0;
    m_req_i = 3'b001; m_we_i = 3'b001; m_addr_i[0] = 32'h0010_0044;
    m_wdata_i[0] = 32'h1234_5678; m_be_i[0] = 4'hF; s_gnt_i = 3'b010; exp_gnt.push_back(0);
    @(negedge clk);
    chk("t1_swe_w", 64'(s_we_o), 64'h2);
    chk("t1_swdata", 64'(s_wdata_o[1]), 64'h1234_5678);
    chk("t1_sbe", 64'(s_be_o[1]), 64'hF);
    nxt(); m_req_i = '0; m_we_i = '0; s_gnt_i = '0;
    s_rvalid_i = 3'b010; s_rdata_i[1] = 32'h0000_0077; exp_rsp.push_back(mk(0, 1'b0, 32'h0000_0077));
    @(negedge clk);
    nxt(); s_rvalid_i = '0;

    // Contention on slave 0; slave grants always and answers one cycle after each grant.
    m_addr_i[0] = 32'h0000_1000; m_addr_i[1] = 32'h0000_1004; m_addr_i[2] = 32'h0000_1008;
    for (int i = 0; i < 6; i++) begin
      m_req_i = 3'b111; s_gnt_i = 3'b001;
      exp_gnt.push_back(ord[i]);
      if (i > 0) begin
        s_rvalid_i = 3'b001; s_rdata_i[0] = 32'hC000_0000 + 32'(i);
        exp_rsp.push_back(mk(ord[i-1], 1'b0, 32'hC000_0000 + 32'(i)));
      end
      @(negedge clk);
      chk("t2_saddr", 64'(s_addr_o[0]), 64'h1000 + 64'(4 * ord[i]));
      nxt();
    end
    m_req_i = '0; s_gnt_i = '0; s_rvalid_i = 3'b001; s_rdata_i[0] = 32'hC000_0006;
    exp_rsp.push_back(mk(2, 1'b0, 32'hC000_0006));
    @(negedge clk);
    nxt(); s_rvalid_i = '0;

    // Decode error from master 2.
    m_req_i = 3'b100; m_addr_i[2] = 32'h2000_0000; exp_gnt.push_back(2);
    @(negedge clk);
    chk("t3_sreq", 64'(s_req_o), 64'd0);
    chk("t3_rvalid_early", 64'(m_rvalid_o), 64'd0);
    nxt(); m_req_i = '0; exp_rsp.push_back(mk(2, 1'b1, 32'h0));
    @(negedge clk);
    chk("t3_sreq_next", 64'(s_req_o), 64'd0);
    nxt();

    // FIFO full on slave 2.
    m_addr_i[0] = 32'h1A10_0100; m_addr_i[1] = 32'h1A10_0200; m_addr_i[2] = 32'h1A10_0300;
    m_req_i = 3'b111; s_gnt_i = 3'b100; exp_gnt.push_back(0);
    @(negedge clk);
    chk("t4_sreq0", 64'(s_req_o), 64'h4);
    chk("t4_saddr0", 64'(s_addr_o[2]), 64'h1A10_0100);
    nxt(); exp_gnt.push_back(1);
    @(negedge clk);
    chk("t4_saddr1", 64'(s_addr_o[2]), 64'h1A10_0200);
    for (int i = 0; i < 2; i++) begin
      nxt();
      @(negedge clk);
      chk("t4_full_sreq", 64'(s_req_o), 64'd0);
      chk("t4_full_saddr", 64'(s_addr_o[2]), 64'd0);
    end
    nxt(); s_rvalid_i = 3'b100; s_rdata_i[2] = 32'hAAAA_0001; exp_rsp.push_back(mk(0, 1'b0, 32'hAAAA_0001));
    @(negedge clk);
    nxt(); m_req_i = 3'b100; s_rdata_i[2] = 32'hAAAA_0002;
    exp_rsp.push_back(mk(1, 1'b0, 32'hAAAA_0002)); exp_gnt.push_back(2);
    @(negedge clk);
    chk("t4_sreq2", 64'(s_req_o), 64'h4);
    chk("t4_saddr2", 64'(s_addr_o[2]), 64'h1A10_0300);
    nxt(); m_req_i = '0; s_gnt_i = '0; s_rdata_i[2] = 32'hAAAA_0003;
    exp_rsp.push_back(mk(2, 1'b0, 32'hAAAA_0003));
    @(negedge clk);
    nxt(); s_rvalid_i = '0;

    // Spurious response on slave 1.
    s_rvalid_i = 3'b010; s_rdata_i[1] = 32'h5555_5555;
    @(negedge clk);
    chk("t5_proto", 64'(proto_err_o), 64'd1);
    chk("t5_no_rvalid", 64'(m_rvalid_o), 64'd0);
    nxt(); s_rvalid_i = '0;
    @(negedge clk);
    chk("t5_proto_pulse", 64'(proto_err_o), 64'd0);

    // Reset with two transactions outstanding.
    nxt(); m_req_i = 3'b011; m_addr_i[0] = 32'h0010_0000; m_addr_i[1] = 32'h1A10_0000;
    s_gnt_i = 3'b110; exp_gnt.push_back(0); exp_gnt.push_back(1);
    @(negedge clk);
    chk("t6_sreq", 64'(s_req_o), 64'h6);
    nxt(); m_req_i = '0; s_gnt_i = '0; rst_n = 1'b0;
    #1;
    chk("t6_rst_gnt", 64'(m_gnt_o), 64'd0);
    chk("t6_rst_rvalid", 64'(m_rvalid_o), 64'd0);
    chk("t6_rst_err", 64'(m_err_o), 64'd0);
    chk("t6_rst_sreq", 64'(s_req_o), 64'd0);
    nxt(); rst_n = 1'b1; s_rvalid_i = 3'b110; s_rdata_i[1] = 32'h1111_1111; s_rdata_i[2] = 32'h2222_2222;
    @(negedge clk);
    chk("t6_late_proto", 64'(proto_err_o), 64'd1);
    chk("t6_late_rvalid", 64'(m_rvalid_o), 64'd0);
    nxt(); s_rvalid_i = '0;
    m_req_i = 3'b001; m_addr_i[0] = 32'h0010_0000; s_gnt_i = 3'b010; exp_gnt.push_back(0);
    @(negedge clk);
    chk("t6_regrant_sreq", 64'(s_req_o), 64'h2);
    nxt(); m_req_i = '0; s_gnt_i = '0; s_rvalid_i = 3'b010; s_rdata_i[1] = 32'h0BAD_F00D;
    exp_rsp.push_back(mk(0, 1'b0, 32'h0BAD_F00D));
    @(negedge clk);
    nxt(); s_rvalid_i = '0;
    @(negedge clk);

    chk("gnt_queue_drained", 64'(exp_gnt.size()), 64'd0);
    chk("rsp_queue_drained", 64'(exp_rsp.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
